// File: rtl/mem_req_demux2.sv
// mem_req_demux2: 1-to-2 memory request router with in-order response merge.
// Define DEMUX_RSP_REG_EN to register the merged response (1-cycle latency).
module mem_req_demux2 #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_req_valid,
  output logic              s_req_ready,
  input  logic              s_req_sel,
  input  logic              s_req_wr,
  input  logic [ADDR_W-1:0] s_req_addr,
  input  logic [DATA_W-1:0] s_req_wdata,
  output logic              m0_req_valid,
  input  logic              m0_req_ready,
  output logic              m0_req_wr,
  output logic [ADDR_W-1:0] m0_req_addr,
  output logic [DATA_W-1:0] m0_req_wdata,
  output logic              m1_req_valid,
  input  logic              m1_req_ready,
  output logic              m1_req_wr,
  output logic [ADDR_W-1:0] m1_req_addr,
  output logic [DATA_W-1:0] m1_req_wdata,
  input  logic              m0_rsp_valid,
  input  logic [DATA_W-1:0] m0_rsp_rdata,
  input  logic              m1_rsp_valid,
  input  logic [DATA_W-1:0] m1_rsp_rdata,
  output logic              s_rsp_valid,
  output logic [DATA_W-1:0] s_rsp_rdata,
  output logic              rsp_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              err_q, err_d;
  logic              cnt_nz;
  logic              allowed;
  logic              accept;
  logic              good0, good1, good;
  logic              spur;
  logic [DATA_W-1:0] rdata_c;

  assign cnt_nz  = (cnt_q != '0);
  assign allowed = !cnt_nz ||
                   ((s_req_sel == sel_q) && (cnt_q < MAX_C));

  // Valids never look at ready; resetn gating keeps them low in reset.
  assign m0_req_valid = resetn && s_req_valid && !s_req_sel && allowed;
  assign m1_req_valid = resetn && s_req_valid && s_req_sel && allowed;
  assign s_req_ready  = resetn && allowed &&
                        (s_req_sel ? m1_req_ready : m0_req_ready);
  assign accept       = s_req_valid && s_req_ready;

  assign m0_req_wr    = s_req_wr;
  assign m0_req_addr  = s_req_addr;
  assign m0_req_wdata = s_req_wdata;
  assign m1_req_wr    = s_req_wr;
  assign m1_req_addr  = s_req_addr;
  assign m1_req_wdata = s_req_wdata;

  assign good0 = m0_rsp_valid && !sel_q && cnt_nz;
  assign good1 = m1_rsp_valid && sel_q && cnt_nz;
  assign good  = good0 || good1;
  assign spur  = (m0_rsp_valid && !good0) ||
                 (m1_rsp_valid && !good1);

  always_comb begin
    rdata_c = '0;
    if (good1)
      rdata_c = m1_rsp_rdata;
    else if (good0)
      rdata_c = m0_rsp_rdata;
  end

  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    err_d = err_q || spur;
    unique case (1'b1)
      accept && !good: cnt_d = cnt_q + 1'b1;
      good && !accept: cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
    if (accept && !cnt_nz)
      sel_d = s_req_sel;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      sel_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;

`ifdef DEMUX_RSP_REG_EN
  logic              rv_q;
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rv_q <= 1'b0;
      rd_q <= '0;
    end else begin
      rv_q <= good;
      rd_q <= rdata_c;
    end
  end

  assign s_rsp_valid = rv_q;
  assign s_rsp_rdata = rd_q;
`else
  assign s_rsp_valid = good;
  assign s_rsp_rdata = rdata_c;
`endif

endmodule

// File: tb/tb_mem_req_demux2.sv
// tb_mem_req_demux2: randomized and directed checks of mem_req_demux2
// against a queue-based model of the outstanding-request ordering.
module tb_mem_req_demux2;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          s_req_valid, s_req_ready, s_req_sel, s_req_wr;
  logic [AW-1:0] s_req_addr;
  logic [DW-1:0] s_req_wdata;
  logic          m0_req_valid, m0_req_ready, m0_req_wr;
  logic [AW-1:0] m0_req_addr;
  logic [DW-1:0] m0_req_wdata;
  logic          m1_req_valid, m1_req_ready, m1_req_wr;
  logic [AW-1:0] m1_req_addr;
  logic [DW-1:0] m1_req_wdata;
  logic          m0_rsp_valid, m1_rsp_valid;
  logic [DW-1:0] m0_rsp_rdata, m1_rsp_rdata;
  logic          s_rsp_valid;
  logic [DW-1:0] s_rsp_rdata;
  logic          rsp_err;

  mem_req_demux2 #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_sel(s_req_sel), .s_req_wr(s_req_wr),
    .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
    .m0_req_wr(m0_req_wr), .m0_req_addr(m0_req_addr),
    .m0_req_wdata(m0_req_wdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
    .m1_req_wr(m1_req_wr), .m1_req_addr(m1_req_addr),
    .m1_req_wdata(m1_req_wdata),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
    .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: queue of ports owning in-flight requests, oldest first.
  bit          q[$];
  bit          err_m;
  bit          pend_v;
  bit [DW-1:0] pend_d;

  bit          exp_m0v, exp_m1v, exp_rdy, exp_rv, exp_err;
  bit [DW-1:0] exp_rd;
  bit          nxt_acc, nxt_good, nxt_spur;
  bit [DW-1:0] nxt_rd;

  task automatic model_reset();
    q.delete();
    err_m  = 1'b0;
    pend_v = 1'b0;
    pend_d = '0;
  endtask

  task automatic eval();
    bit alw, g0, g1;
    alw = (q.size() == 0) ||
          (s_req_sel == q[0] && q.size() < MAXO);
    exp_m0v = s_req_valid && !s_req_sel && alw;
    exp_m1v = s_req_valid && s_req_sel && alw;
    exp_rdy = alw && (s_req_sel ? m1_req_ready : m0_req_ready);
    g0 = m0_rsp_valid && q.size() > 0 && q[0] == 1'b0;
    g1 = m1_rsp_valid && q.size() > 0 && q[0] == 1'b1;
    nxt_acc  = s_req_valid && exp_rdy;
    nxt_good = g0 || g1;
    nxt_spur = (m0_rsp_valid && !g0) || (m1_rsp_valid && !g1);
    nxt_rd   = g1 ? m1_rsp_rdata : (g0 ? m0_rsp_rdata : '0);
`ifdef DEMUX_RSP_REG_EN
    exp_rv = pend_v;
    exp_rd = pend_d;
`else
    exp_rv = nxt_good;
    exp_rd = nxt_rd;
`endif
    exp_err = err_m;
    #1;
  endtask

  task automatic tick();
    bit s;
    s = s_req_sel;
    @(posedge clk);
    if (nxt_good) void'(q.pop_front());
    if (nxt_acc) q.push_back(s);
    err_m  = err_m || nxt_spur;
    pend_v = nxt_good;
    pend_d = nxt_rd;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s_req_valid  = 1'b0;
    s_req_sel    = 1'b0;
    s_req_wr     = 1'b0;
    s_req_addr   = '0;
    s_req_wdata  = '0;
    m0_req_ready = 1'b1;
    m1_req_ready = 1'b1;
    m0_rsp_valid = 1'b0;
    m1_rsp_valid = 1'b0;
    m0_rsp_rdata = '0;
    m1_rsp_rdata = '0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 2 * MAXO + 2 && q.size() > 0; i++) begin
      m0_rsp_valid = (q[0] == 1'b0);
      m1_rsp_valid = (q[0] == 1'b1);
      m0_rsp_rdata = $urandom;
      m1_rsp_rdata = $urandom;
      eval();
      checks++;
      if (s_rsp_valid !== exp_rv || s_rsp_rdata !== exp_rd) begin
        errors++;
        $display("FAIL drain_rsp: got %b/%h want %b/%h",
                 s_rsp_valid, s_rsp_rdata, exp_rv, exp_rd);
      end
      tick();
    end
    idle_inputs();
    eval();
    checks++;
    if (s_rsp_valid !== exp_rv || s_rsp_rdata !== exp_rd ||
        q.size() != 0) begin
      errors++;
      $display("FAIL drain_flush: got %b/%h want %b/%h left=%0d",
               s_rsp_valid, s_rsp_rdata, exp_rv, exp_rd, q.size());
    end
    tick();
  endtask

  task automatic push_req(input bit sel);
    s_req_valid = 1'b1;
    s_req_sel   = sel;
    s_req_addr  = $urandom;
    s_req_wdata = $urandom;
    s_req_wr    = 1'(($urandom));
    eval();
    checks++;
    if (s_req_ready !== exp_rdy || m0_req_valid !== exp_m0v ||
        m1_req_valid !== exp_m1v) begin
      errors++;
      $display("FAIL push_req: rdy/v0/v1 got %b%b%b want %b%b%b",
               s_req_ready, m0_req_valid, m1_req_valid,
               exp_rdy, exp_m0v, exp_m1v);
    end
    tick();
    s_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    s_req_valid  = 1'b1;
    m0_rsp_valid = 1'b1;
    m0_rsp_rdata = 32'hFFFF_FFFF;
    resetn = 1'b0;
    model_reset();
    #7;
    checks++;
    if (m0_req_valid !== 1'b0 || m1_req_valid !== 1'b0 ||
        s_rsp_valid !== 1'b0 || s_rsp_rdata !== '0 ||
        rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: v0=%b v1=%b rv=%b rd=%h err=%b",
               m0_req_valid, m1_req_valid, s_rsp_valid,
               s_rsp_rdata, rsp_err);
    end
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    s_req_valid = 1'b1;
    s_req_sel   = 1'b0;
    s_req_wr    = 1'b0;
    s_req_addr  = 32'h1FC0_0000;
    s_req_wdata = 32'hA5A5_0001;
    eval();
    checks++;
    if (m0_req_valid !== 1'b1 || m1_req_valid !== 1'b0 ||
        s_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_req: v0=%b v1=%b rdy=%b want 1 0 1",
               m0_req_valid, m1_req_valid, s_req_ready);
    end
    checks++;
    if (m0_req_addr !== 32'h1FC0_0000 || m1_req_addr !== 32'h1FC0_0000 ||
        m1_req_wdata !== 32'hA5A5_0001 || m0_req_wr !== 1'b0) begin
      errors++;
      $display("FAIL single_fanout: a0=%h a1=%h wd1=%h",
               m0_req_addr, m1_req_addr, m1_req_wdata);
    end
    tick();
    idle_inputs();
    m0_rsp_valid = 1'b1;
    m0_rsp_rdata = 32'hDEAD_BEEF;
    eval();
`ifndef DEMUX_RSP_REG_EN
    checks++;
    if (s_rsp_valid !== 1'b1 || s_rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_rsp: got %b/%h want 1/deadbeef",
               s_rsp_valid, s_rsp_rdata);
    end
`endif
    tick();
    idle_inputs();
    eval();
    checks++;
`ifdef DEMUX_RSP_REG_EN
    if (s_rsp_valid !== 1'b1 || s_rsp_rdata !== 32'hDEAD_BEEF) begin
`else
    if (s_rsp_valid !== 1'b0 || s_rsp_rdata !== '0) begin
`endif
      errors++;
      $display("FAIL single_rsp_next: got %b/%h", s_rsp_valid, s_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_saturation();
    idle_inputs();
    for (int i = 0; i < MAXO; i++) push_req(1'b1);
    s_req_valid  = 1'b1;
    s_req_sel    = 1'b1;
    m1_rsp_valid = 1'b1;
    m1_rsp_rdata = 32'h0000_5A7A;
    eval();
    checks++;
    if (s_req_ready !== 1'b0 || m1_req_valid !== 1'b0 ||
        exp_rdy !== 1'b0) begin
      errors++;
      $display("FAIL sat_stall: rdy=%b v1=%b want 0 0",
               s_req_ready, m1_req_valid);
    end
    tick();
    m1_rsp_valid = 1'b0;
    eval();
    checks++;
    if (s_req_ready !== 1'b1 || m1_req_valid !== 1'b1 ||
        s_rsp_valid !== exp_rv || s_rsp_rdata !== exp_rd) begin
      errors++;
      $display("FAIL sat_resume: rdy=%b v1=%b rsp=%b/%h",
               s_req_ready, m1_req_valid, s_rsp_valid, s_rsp_rdata);
    end
    tick();
    drain();
  endtask

  task automatic test_port_switch();
    idle_inputs();
    push_req(1'b0);
    push_req(1'b0);
    s_req_valid = 1'b1;
    s_req_sel   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m0_rsp_valid = 1'b1;
      m0_rsp_rdata = 32'h0000_1000 + i;
      eval();
      checks++;
      if (m1_req_valid !== 1'b0 || s_req_ready !== 1'b0 ||
          s_rsp_valid !== exp_rv || s_rsp_rdata !== exp_rd) begin
        errors++;
        $display("FAIL switch_stall%0d: v1=%b rdy=%b rsp=%b/%h",
                 i, m1_req_valid, s_req_ready, s_rsp_valid, s_rsp_rdata);
      end
      tick();
    end
    m0_rsp_valid = 1'b0;
    eval();
    checks++;
    if (m1_req_valid !== 1'b1 || s_req_ready !== 1'b1 ||
        s_rsp_valid !== exp_rv) begin
      errors++;
      $display("FAIL switch_accept: v1=%b rdy=%b want 1 1",
               m1_req_valid, s_req_ready);
    end
    tick();
    drain();
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    push_req(1'b0);
    push_req(1'b0);
    s_req_valid  = 1'b1;
    s_req_sel    = 1'b0;
    m0_rsp_valid = 1'b1;
    m0_rsp_rdata = 32'hC0FF_EE00;
    eval();
    checks++;
    if (s_req_ready !== 1'b1 || s_rsp_valid !== exp_rv ||
        s_rsp_rdata !== exp_rd) begin
      errors++;
      $display("FAIL simul: rdy=%b rsp=%b/%h want 1 %b/%h",
               s_req_ready, s_rsp_valid, s_rsp_rdata, exp_rv, exp_rd);
    end
    tick();
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      s_req_valid  = 1'(($urandom_range(0, 1)));
      s_req_sel    = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                     q[0] : 1'(($urandom));
      s_req_wr     = 1'(($urandom));
      s_req_addr   = $urandom;
      s_req_wdata  = $urandom;
      m0_req_ready = ($urandom_range(0, 3) != 0);
      m1_req_ready = ($urandom_range(0, 3) != 0);
      m0_rsp_valid = 1'b0;
      m1_rsp_valid = 1'b0;
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        m0_rsp_valid = (q[0] == 1'b0);
        m1_rsp_valid = (q[0] == 1'b1);
      end
      if ($urandom_range(0, 39) == 0) m0_rsp_valid = 1'b1;
      m0_rsp_rdata = $urandom;
      m1_rsp_rdata = $urandom;
      eval();
      checks++;
      if (m0_req_valid !== exp_m0v || m1_req_valid !== exp_m1v ||
          s_req_ready !== exp_rdy || s_rsp_valid !== exp_rv ||
          s_rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
        errors++;
        $display("FAIL rand_c%0d: v0v1rdy=%b%b%b rsp=%b/%h err=%b want %b%b%b %b/%h %b",
                 c, m0_req_valid, m1_req_valid, s_req_ready,
                 s_rsp_valid, s_rsp_rdata, rsp_err,
                 exp_m0v, exp_m1v, exp_rdy, exp_rv, exp_rd, exp_err);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_spurious();
    idle_inputs();
    push_req(1'b0);
    m1_rsp_valid = 1'b1;
    m1_rsp_rdata = 32'h1234_5678;
    eval();
    checks++;
    if (s_rsp_valid !== 1'b0 || s_rsp_rdata !== '0) begin
      errors++;
      $display("FAIL spur_drop: rsp=%b/%h want 0/0", s_rsp_valid, s_rsp_rdata);
    end
    tick();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      eval();
      checks++;
      if (rsp_err !== 1'b1 || s_rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL spur_err%0d: err=%b rv=%b want 1 0",
                 i, rsp_err, s_rsp_valid);
      end
      tick();
    end
    drain();
    eval();
    checks++;
    if (rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL spur_sticky: err=%b want 1", rsp_err);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    idle_inputs();
    for (int i = 0; i < 3; i++) push_req(1'b1);
    s_req_valid = 1'b1;
    s_req_sel   = 1'b0;
    eval();
    checks++;
    if (s_req_ready !== 1'b0 || m0_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre: rdy=%b v0=%b want 0 0",
               s_req_ready, m0_req_valid);
    end
    resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rsp_err !== 1'b0 || m0_req_valid !== 1'b0 ||
        s_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: err=%b v0=%b rv=%b want 0 0 0",
               rsp_err, m0_req_valid, s_rsp_valid);
    end
    #1;
    resetn = 1'b1;
    eval();
    checks++;
    if (s_req_ready !== 1'b1 || m0_req_valid !== 1'b1 ||
        m1_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: rdy=%b v0=%b v1=%b want 1 1 0",
               s_req_ready, m0_req_valid, m1_req_valid);
    end
    tick();
    drain();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_saturation();
    test_port_switch();
    test_simultaneous();
    test_random();
    test_spurious();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_req_demux2.md
Name: mem_req_demux2

Overview:
- 1-to-2 request router: steers a single CPU-side memory request channel to one of two downstream ports, e.g. cached vs uncached path.
- Per-request selection bit `s_req_sel`.
- Merges the two response streams back into one, in order.
- Tracks outstanding transactions so responses can never return out of order across ports.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, write/read data width.
- MAX_OUTSTANDING, 4, max in-flight requests (legal 1..15); counter width is clog2(MAX_OUTSTANDING+1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- s_req_valid  input  1  upstream request valid.
- s_req_ready  output  1  upstream request accepted when valid & ready.
- s_req_sel  input  1  target port: 0 selects m0, 1 selects m1.
- s_req_wr  input  1  1 = write, 0 = read.
- s_req_addr  input  ADDR_W  request address.
- s_req_wdata  input  DATA_W  write data.
- m0_req_valid, m1_req_valid  output  1  downstream request valid.
- m0_req_ready, m1_req_ready  input  1  downstream request ready.
- m0_req_wr, m1_req_wr  output  1  copy of s_req_wr.
- m0_req_addr, m1_req_addr  output  ADDR_W  copy of s_req_addr.
- m0_req_wdata, m1_req_wdata  output  DATA_W  copy of s_req_wdata.
- m0_rsp_valid, m1_rsp_valid  input  1  downstream response (one per request; read or write-ack).
- m0_rsp_rdata, m1_rsp_rdata  input  DATA_W  response data.
- s_rsp_valid  output  1  merged response; no backpressure, upstream always accepts.
- s_rsp_rdata  output  DATA_W  merged response data.
- rsp_err  output  1  sticky spurious-response flag.

Behaviour:
- State registers: cnt (outstanding count), cur_sel (port owning in-flight traffic), rsp_err.
- Reset values: cnt=0, cur_sel=0, rsp_err=0. Outputs during reset: s_rsp_valid=0, s_rsp_rdata=0, m*_req_valid=0.
- allowed = (cnt==0) | (s_req_sel==cur_sel & cnt<MAX_OUTSTANDING). Uses registered cnt only.
- mN_req_valid = s_req_valid & (s_req_sel==N) & allowed. It must not depend on any ready, so there is no combinational loop.
- s_req_ready = allowed & mN_req_ready of the selected port.
- Request payload fans out unconditionally to both ports; only the valids are gated.
- Request path latency is 0 cycles (combinational pass-through).
- Accept (s_req_valid & s_req_ready):
  - cnt increments.
  - If cnt==0, cur_sel loads s_req_sel.
- Good response: mN_rsp_valid with N==cur_sel and cnt>0.
  - s_rsp_valid=1 and s_rsp_rdata=mN_rsp_rdata in the same cycle.
  - cnt decrements.
- Accept and good response in the same cycle: cnt unchanged.
- Spurious response: any response from port != cur_sel, or any response with cnt==0.
  - Dropped; s_rsp_valid stays 0.
  - rsp_err set to 1 next edge; clears only on reset.
- Both rsp_valids in the same cycle: only the cur_sel one is forwarded; the other is spurious.
- Port switch: a request to the other port stalls (ready=0, its valid=0) until cnt==0 is registered. It is accepted at the earliest one cycle after the last response.
- cnt saturation: at cnt==MAX_OUTSTANDING, same-port requests stall until a response arrives.
- s_rsp_rdata when s_rsp_valid=0: 0.
- Reset mid-operation: all state clears immediately (asynchronous). Responses for pre-reset requests are the downstream's responsibility (downstream shares resetn).

Optional Feature:
- Macro DEMUX_RSP_REG_EN.
- Defined:
  - s_rsp_valid and s_rsp_rdata are registered, giving 1-cycle response latency; both reset to 0.
  - cnt still decrements on the cycle the downstream response arrives.
  - rsp_err timing unchanged.
- Undefined: combinational 0-cycle response path, as described above.

Test Plan:
- Single read: sel=0, addr=0x1FC00000, m0_req_ready=1 → m0_req_valid=1 same cycle, m1_req_valid=0, cnt=1. m0_rsp_valid with 0xDEADBEEF → s_rsp_valid=1 with 0xDEADBEEF same cycle, cnt=0.
- Saturation: 4 back-to-back sel=1 requests, no responses → all accepted, cnt=4. 5th request: s_req_ready=0. One m1 response → 5th request accepted the following cycle.
- Port switch: 2 outstanding to m0, then sel=1 request held → m1_req_valid=0 until both m0 responses. Accepted the cycle after cnt reaches 0, cur_sel=1.
- Simultaneous: cnt=2, accept same-port request plus good response in one cycle → cnt stays 2, s_rsp_valid=1.
- Spurious: cur_sel=0, cnt=1, m1_rsp_valid pulse with 0x12345678 → s_rsp_valid=0, rsp_err=1 next cycle and stays 1. cnt remains 1.
- Reset mid-flight: cnt=3, cur_sel=1, pulse resetn=0 asynchronously → cnt=0, cur_sel=0, rsp_err=0. A new sel=0 request is accepted immediately after release. With DEMUX_RSP_REG_EN, repeat test 1 and expect s_rsp_valid one cycle later.
